pe_ws_controller: RTL

- Sequencer for one weight-stationary PE: fills the PE weight scratchpad, then runs one streaming pass per stored weight.
- Drives all PE control pins: scratchpad read/write, ws_en/ws_mux, output-register enable/reset.
- Sits between the array-level scheduler (start/config, weight stream, activation-beat handshake) and a single PE.
- Activation and partial-sum data go straight to the PE; this block only gates them.

---
 rtl/pe_ws_controller.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/pe_ws_controller.sv
// Weight-stationary PE sequencer: loads the PE weight scratchpad from a
// weight stream, then runs one activation pass per stored weight, driving
// every PE control pin combinationally from the current state and handshakes.
module pe_ws_controller #(
    parameter int MEM_ADDR_BITWIDTH = 10,
    parameter int WGT_BITWIDTH      = 8,
    parameter int ACT_CNT_BITWIDTH  = 16
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         start,
    input  logic [MEM_ADDR_BITWIDTH:0]   num_wgt_cfg,
    input  logic [ACT_CNT_BITWIDTH-1:0]  num_act_cfg,
    input  logic                         wgt_valid,
    output logic                         wgt_ready,
    input  logic [WGT_BITWIDTH-1:0]      wgt_data,
    input  logic                         act_valid,
    output logic                         act_ready,
    output logic                         busy,
    output logic                         done,
    output logic                         reset_w_mem,
    output logic                         read_req_w_mem,
    output logic                         write_req_w_mem,
    output logic [MEM_ADDR_BITWIDTH-1:0] w_addr_w_mem,
    output logic [MEM_ADDR_BITWIDTH-1:0] r_addr_w_mem,
    output logic [WGT_BITWIDTH-1:0]      w_data_w_mem,
    output logic                         ws_en,
    output logic                         ws_mux,
    output logic                         reset_ws_reg,
    output logic                         wrt_en_reg,
    output logic                         reset_reg
);
    localparam int AW = MEM_ADDR_BITWIDTH;
    localparam int CW = MEM_ADDR_BITWIDTH + 1;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOAD   = 3'd1;
    localparam logic [2:0] S_FETCH  = 3'd2;
    localparam logic [2:0] S_STREAM = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

    logic [2:0]                  state;
    logic [CW-1:0]               num_wgt;
    logic [ACT_CNT_BITWIDTH-1:0] num_act;
    // Index counters carry one extra bit so a full 2^AW load never wraps.
    logic [CW-1:0]               load_idx;
    logic [CW-1:0]               wgt_idx;
    logic [ACT_CNT_BITWIDTH-1:0] act_cnt;
    logic                        first_beat;
    logic [AW-1:0]               w_addr_q;
    logic [AW-1:0]               r_addr_q;

    logic in_idle, in_load, in_fetch, in_stream, in_done;
    logic start_fire, wgt_fire, act_fire;
    logic last_load, last_beat, last_pass, empty_job;

    // State decode, gated by reset_n so nothing asserts while held in reset.
    always_comb begin
        in_idle    = reset_n && (state == S_IDLE);
        in_load    = reset_n && (state == S_LOAD);
        in_fetch   = reset_n && (state == S_FETCH);
        in_stream  = reset_n && (state == S_STREAM);
        in_done    = reset_n && (state == S_DONE);
        start_fire = in_idle && start;
        wgt_fire   = in_load && wgt_valid;
        act_fire   = in_stream && act_valid;
        last_load  = (load_idx == num_wgt - CW'(1));
        last_beat  = (act_cnt == num_act - ACT_CNT_BITWIDTH'(1));
        last_pass  = (wgt_idx == num_wgt - CW'(1));
        empty_job  = (num_wgt_cfg == '0) || (num_act_cfg == '0);
    end

    // PE control pins; addresses hold their last value while the request is low.
    always_comb begin
        busy            = reset_n && (state != S_IDLE);
        done            = in_done;
        wgt_ready       = in_load;
        act_ready       = in_stream;
        reset_w_mem     = start_fire;
        reset_ws_reg    = start_fire;
        reset_reg       = start_fire;
        write_req_w_mem = wgt_fire;
        w_addr_w_mem    = wgt_fire ? load_idx[AW-1:0] : w_addr_q;
        w_data_w_mem    = reset_n ? wgt_data : '0;
        read_req_w_mem  = in_fetch;
        r_addr_w_mem    = in_fetch ? wgt_idx[AW-1:0] : r_addr_q;
        wrt_en_reg      = act_fire;
        ws_mux          = in_stream && first_beat;
        ws_en           = act_fire && first_beat;
    end

    // Sequencer state, configuration capture and counters.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            num_wgt    <= '0;
            num_act    <= '0;
            load_idx   <= '0;
            wgt_idx    <= '0;
            act_cnt    <= '0;
            first_beat <= 1'b0;
            w_addr_q   <= '0;
            r_addr_q   <= '0;
        end else begin
            if (wgt_fire) w_addr_q <= load_idx[AW-1:0];
            if (in_fetch) r_addr_q <= wgt_idx[AW-1:0];
            case (state)
                S_IDLE: if (start) begin
                    num_wgt  <= num_wgt_cfg;
                    num_act  <= num_act_cfg;
                    load_idx <= '0;
                    wgt_idx  <= '0;
                    act_cnt  <= '0;
                    state    <= empty_job ? S_DONE : S_LOAD;
                end
                S_LOAD: if (wgt_fire) begin
                    load_idx <= load_idx + CW'(1);
                    if (last_load) begin
                        wgt_idx <= '0;
                        state   <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    first_beat <= 1'b1;
                    act_cnt    <= '0;
                    state      <= S_STREAM;
                end
                S_STREAM: if (act_fire) begin
                    first_beat <= 1'b0;
                    act_cnt    <= act_cnt + ACT_CNT_BITWIDTH'(1);
                    if (last_beat) begin
                        if (last_pass) begin
                            state <= S_DONE;
                        end else begin
                            wgt_idx <= wgt_idx + CW'(1);
                            state   <= S_FETCH;
                        end
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
